jtag_tap_ir: RTL and testbench

- JTAG TAP controller plus instruction register.
- Sits directly upstream of the G1 TDO mux and drives its 4-bit CODE select.
- Also drives the data-register shift/capture/update strobes shared by the BSR, BYPASS, DEVICE_ID and BIST registers.
- Provides the IR serial output and the TDO enable/select used by the pad stage.

---
 rtl/jtag_tap_ir_if.sv | 27 ++
 rtl/jtag_tap_ir.sv | 132 +++++++++++++
 tb/tb_jtag_tap_ir.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_ir_if.sv
// Bundle for the JTAG TAP + IR block: serial test inputs, capture status,
// instruction decode to the TDO mux, DR strobes and pad-stage TDO controls.
interface jtag_tap_ir_if;
  logic       TMS;
  logic       TDI;
  logic [1:0] IR_STATUS;
  logic [3:0] CODE;
  logic       CAPTURE_DR;
  logic       SHIFT_DR;
  logic       UPDATE_DR;
  logic       IR_TDO;
  logic       TDO_SEL_IR;
  logic       TDO_EN;
  logic [3:0] TAP_STATE;

  // Test-access side: drives TMS/TDI/status, observes everything else.
  modport master (
    output TMS, TDI, IR_STATUS,
    input  CODE, CAPTURE_DR, SHIFT_DR, UPDATE_DR, IR_TDO, TDO_SEL_IR, TDO_EN, TAP_STATE
  );

  // TAP controller side.
  modport slave (
    input  TMS, TDI, IR_STATUS,
    output CODE, CAPTURE_DR, SHIFT_DR, UPDATE_DR, IR_TDO, TDO_SEL_IR, TDO_EN, TAP_STATE
  );
endinterface

// File: rtl/jtag_tap_ir.sv
// JTAG TAP controller (IEEE 1149.1 16-state FSM) with instruction register.
// Drives the 4-bit CODE select of the downstream TDO mux, the shared DR
// capture/shift/update strobes, and the IR serial output / TDO controls.
// Optional feature macro: JTAG_IR_STATUS_EN -- when defined, Capture-IR loads
// IR_STATUS into bits [3:2]; otherwise IR_STATUS is ignored.
module jtag_tap_ir #(
  parameter int         IR_WIDTH     = 4,
  parameter logic [3:0] RESET_OPCODE = 4'h2
) (
  input  logic          TCK,
  input  logic          RST,
  jtag_tap_ir_if.slave  bus
);

  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PA_DR  = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PA_IR  = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] RESET_IR = IR_WIDTH'(RESET_OPCODE);

  tap_state_t          state;
  logic                capture_dr;
  logic                shift_dr;
  logic                update_dr;
  logic                tdo_sel_ir;
  logic                tdo_en;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_update;
  logic [IR_WIDTH-1:0] cap_val;

  // Standard TAP transition table, one step per TCK edge.
  function automatic tap_state_t next_state(input tap_state_t cur, input logic tms);
    tap_state_t nxt;
    case (cur)
      TLR:     nxt = tms ? TLR    : RTI;
      RTI:     nxt = tms ? SEL_DR : RTI;
      SEL_DR:  nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:  nxt = tms ? EX1_DR : SH_DR;
      SH_DR:   nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:  nxt = tms ? UPD_DR : PA_DR;
      PA_DR:   nxt = tms ? EX2_DR : PA_DR;
      EX2_DR:  nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:  nxt = tms ? SEL_DR : RTI;
      SEL_IR:  nxt = tms ? TLR    : CAP_IR;
      CAP_IR:  nxt = tms ? EX1_IR : SH_IR;
      SH_IR:   nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:  nxt = tms ? UPD_IR : PA_IR;
      PA_IR:   nxt = tms ? EX2_IR : PA_IR;
      EX2_IR:  nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:  nxt = tms ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
    return nxt;
  endfunction

  // State register plus per-state strobes registered from the next state, so
  // each strobe is a flop output that is high exactly while the FSM sits there.
  always_ff @(posedge TCK) begin
    if (RST) begin
      state      <= TLR;
      capture_dr <= 1'b0;
      shift_dr   <= 1'b0;
      update_dr  <= 1'b0;
      tdo_sel_ir <= 1'b0;
      tdo_en     <= 1'b0;
    end else begin
      tap_state_t nxt;
      nxt         = next_state(state, bus.TMS);
      state      <= nxt;
      capture_dr <= (nxt == CAP_DR);
      shift_dr   <= (nxt == SH_DR);
      update_dr  <= (nxt == UPD_DR);
      tdo_sel_ir <= (nxt == SH_IR);
      tdo_en     <= (nxt == SH_IR) || (nxt == SH_DR);
    end
  end

  // Capture-IR pattern: fixed 2'b01 in the LSBs, optional status above it.
  always_comb begin
    cap_val      = '0;
    cap_val[1:0] = 2'b01;
`ifdef JTAG_IR_STATUS_EN
    cap_val[3:2] = bus.IR_STATUS;
`else
    // Status input is present on the port but deliberately masked out.
    cap_val[3:2] = bus.IR_STATUS & 2'b00;
`endif
  end

  // IR datapath, keyed to the state held before the edge; reset and TLR both
  // restore the default opcode so a half-shifted IR can never become active.
  always_ff @(posedge TCK) begin
    if (RST) begin
      ir_shift  <= '0;
      ir_update <= RESET_IR;
    end else begin
      case (state)
        TLR:     ir_update <= RESET_IR;
        CAP_IR:  ir_shift  <= cap_val;
        SH_IR:   ir_shift  <= {bus.TDI, ir_shift[IR_WIDTH-1:1]};
        UPD_IR:  ir_update <= ir_shift;
        default: ;
      endcase
    end
  end

  // Any opcode above 5 (including set upper bits on wider IRs) selects BYPASS.
  assign bus.CODE       = (ir_update > IR_WIDTH'(5)) ? 4'h0 : ir_update[3:0];
  assign bus.CAPTURE_DR = capture_dr;
  assign bus.SHIFT_DR   = shift_dr;
  assign bus.UPDATE_DR  = update_dr;
  assign bus.IR_TDO     = ir_shift[0];
  assign bus.TDO_SEL_IR = tdo_sel_ir;
  assign bus.TDO_EN     = tdo_en;
  assign bus.TAP_STATE  = state;

endmodule

// File: tb/tb_jtag_tap_ir.sv
// Directed bench for jtag_tap_ir: a vector table for reset, the BSR IR load
// and a full DR walk, then hand-written sequences for TLR entry, opcode decode,
// 5-bit IR, pause path, mid-shift reset and the capture-status pattern.
module tb_jtag_tap_ir;

  logic       tck = 1'b0;
  logic       rst = 1'b0;
  logic       tms = 1'b0;
  logic       tdi = 1'b0;
  logic [1:0] ir_status = 2'b00;

  int checks = 0;
  int errors = 0;

  jtag_tap_ir_if if4 ();
  jtag_tap_ir_if if5 ();

  assign if4.TMS = tms;
  assign if4.TDI = tdi;
  assign if4.IR_STATUS = ir_status;
  assign if5.TMS = tms;
  assign if5.TDI = tdi;
  assign if5.IR_STATUS = ir_status;

  jtag_tap_ir dut4 (.TCK(tck), .RST(rst), .bus(if4));
  jtag_tap_ir #(.IR_WIDTH(5)) dut5 (.TCK(tck), .RST(rst), .bus(if5));

  always #5 tck = ~tck;

  // exp packs {state, code, capture_dr, shift_dr, update_dr, tdo_sel_ir, tdo_en, ir_tdo}
  typedef struct {
    logic        rst;
    logic        tms;
    logic        tdi;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [13:0] pk(input logic [3:0] st, input logic [3:0] cd,
                                     input logic cap, input logic sh, input logic upd,
                                     input logic sel, input logic en, input logic tdo);
    return {st, cd, cap, sh, upd, sel, en, tdo};
  endfunction

  function automatic logic [13:0] observe();
    return {if4.TAP_STATE, if4.CODE, if4.CAPTURE_DR, if4.SHIFT_DR, if4.UPDATE_DR,
            if4.TDO_SEL_IR, if4.TDO_EN, if4.IR_TDO};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic d);
    rst = r;
    tms = t;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  // From RTI: shift n bits of val (LSB first) into the IR, update, back to RTI.
  task automatic load_ir(input int n, input logic [7:0] val);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < n; i++) step(0, (i == n - 1), val[i]);
    step(0, 1, 0);
    step(0, 0, 0);
  endtask

  initial begin
    logic feat;
`ifdef JTAG_IR_STATUS_EN
    feat = 1'b1;
`else
    feat = 1'b0;
`endif
    //                     rst tms tdi          st    code  cap sh upd sel en tdo
    vecs[0]  = '{1'b1, 1'b0, 1'b0, pk(4'h0, 4'h2, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, pk(4'h1, 4'h2, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, pk(4'h2, 4'h2, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, pk(4'h9, 4'h2, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, pk(4'hA, 4'h2, 0, 0, 0, 0, 0, 0)};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, pk(4'hB, 4'h2, 0, 0, 0, 1, 1, 1)};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, pk(4'hB, 4'h2, 0, 0, 0, 1, 1, 0)};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, pk(4'hB, 4'h2, 0, 0, 0, 1, 1, 0)};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, pk(4'hB, 4'h2, 0, 0, 0, 1, 1, 0)};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, pk(4'hC, 4'h2, 0, 0, 0, 0, 0, 1)};
    vecs[10] = '{1'b0, 1'b1, 1'b0, pk(4'hF, 4'h2, 0, 0, 0, 0, 0, 1)};
    vecs[11] = '{1'b0, 1'b0, 1'b0, pk(4'h1, 4'h1, 0, 0, 0, 0, 0, 1)};
    vecs[12] = '{1'b0, 1'b1, 1'b0, pk(4'h2, 4'h1, 0, 0, 0, 0, 0, 1)};
    vecs[13] = '{1'b0, 1'b0, 1'b0, pk(4'h3, 4'h1, 1, 0, 0, 0, 0, 1)};
    vecs[14] = '{1'b0, 1'b0, 1'b0, pk(4'h4, 4'h1, 0, 1, 0, 0, 1, 1)};
    vecs[15] = '{1'b0, 1'b1, 1'b0, pk(4'h5, 4'h1, 0, 0, 0, 0, 0, 1)};
    vecs[16] = '{1'b0, 1'b0, 1'b0, pk(4'h6, 4'h1, 0, 0, 0, 0, 0, 1)};
    vecs[17] = '{1'b0, 1'b1, 1'b0, pk(4'h7, 4'h1, 0, 0, 0, 0, 0, 1)};
    vecs[18] = '{1'b0, 1'b1, 1'b0, pk(4'h8, 4'h1, 0, 0, 1, 0, 0, 1)};
    vecs[19] = '{1'b0, 1'b0, 1'b0, pk(4'h1, 4'h1, 0, 0, 0, 0, 0, 1)};

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].rst, vecs[i].tms, vecs[i].tdi);
      chk($sformatf("vec%0d", i), {2'b00, observe()}, {2'b00, vecs[i].exp});
    end

    // SH_DR then five TMS=1 edges into TLR; one more TLR edge restores DEVICE_ID.
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("in_sh_dr", 16'(if4.TAP_STATE), 16'h4);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    chk("tlr_after_5", 16'(if4.TAP_STATE), 16'h0);
    step(0, 1, 0);
    chk("tlr_hold_state", 16'(if4.TAP_STATE), 16'h0);
    chk("tlr_code", 16'(if4.CODE), 16'h2);
    step(0, 0, 0);
    chk("tlr_to_rti", 16'(if4.TAP_STATE), 16'h1);

    // Opcode decode.
    load_ir(4, 8'h09);
    chk("code_op9", 16'(if4.CODE), 16'h0);
    load_ir(4, 8'h0F);
    chk("code_opF", 16'(if4.CODE), 16'h0);
    load_ir(4, 8'h05);
    chk("code_op5", 16'(if4.CODE), 16'h5);
    chk("state_rti", 16'(if4.TAP_STATE), 16'h1);

    // 5-bit shifts: the wide IR sees the full value, the 4-bit IR the last 4 bits.
    load_ir(5, 8'h13);
    chk("w5_code_13", 16'(if5.CODE), 16'h0);
    chk("w4_code_after13", 16'(if4.CODE), 16'h0);
    load_ir(5, 8'h05);
    chk("w5_code_05", 16'(if5.CODE), 16'h5);
    chk("w4_code_after05", 16'(if4.CODE), 16'h2);

    // Pause path: shift 1,1 / pause 3 edges / resume / shift 0,0 -> opcode 3.
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 1, 1);
    chk("pause_ex1", 16'(if4.TAP_STATE), 16'hC);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("pause_pa", 16'(if4.TAP_STATE), 16'hD);
    step(0, 1, 1);
    chk("pause_ex2", 16'(if4.TAP_STATE), 16'hE);
    step(0, 0, 1);
    chk("pause_resh", 16'(if4.TAP_STATE), 16'hB);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("pause_code", 16'(if4.CODE), 16'h3);

    // Reset in the middle of an IR shift.
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 1);
    chk("midrst_state", 16'(if4.TAP_STATE), 16'h0);
    chk("midrst_code", 16'(if4.CODE), 16'h2);
    chk("midrst_tdo", {14'h0, if4.TDO_EN, if4.IR_TDO}, 16'h0);
    step(0, 0, 0);

    // Capture pattern with IR_STATUS = 2'b10.
    ir_status = 2'b10;
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("cap_tdo0", 16'(if4.IR_TDO), 16'h1);
    step(0, 0, 0);
    chk("cap_tdo1", 16'(if4.IR_TDO), 16'h0);
    step(0, 0, 0);
    chk("cap_tdo2", 16'(if4.IR_TDO), 16'h0);
    step(0, 0, 0);
    chk("cap_tdo3", 16'(if4.IR_TDO), 16'(feat));
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("cap_code", 16'(if4.CODE), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
